into_one_minus_one_by_n: RTL and testbench
==========================================

# into_one_minus_one_by_n

Fixed-point scaling block that computes Prod = D × (1 − 1/N), given D and a precomputed reciprocal 1/N. It sits in the OCR datapath wherever a running quantity must be attenuated by the factor (N−1)/N, for example in averaging or normalisation stages. It is a fully pipelined, single-clock unit that accepts one operand pair per cycle.

## Interface
- D_W, 32: width of D and Prod (unsigned).
- FRAC, 16: fractional bits of One_by_N; 1.0 = 2^FRAC = 65536.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  D and One_by_N are sampled on this cycle.
- D  in  32  unsigned operand; Prod uses the same scale as D.
- One_by_N  in  17  unsigned Q1.16 reciprocal; 32768 = 0.5, 65536 = 1.0.
- out_valid  out  1  Prod holds a new result on this cycle.
- Prod  out  32  unsigned result, floor(D × (65536 − One_by_N) / 65536).

## Operation
- Factor F = 65536 − One_by_N, as 17-bit unsigned.
- If One_by_N > 65536, F is clamped to 0, so Prod = 0.
- One_by_N = 0 gives F = 65536, so Prod = D exactly.
- Full product P = D × F is 49 bits.
- Prod = P[47:16]. Truncation toward zero; no rounding.
- Prod ≤ D always, so the result never overflows 32 bits.
- Unsigned arithmetic throughout; no sign handling.
- Multiply split: D × F[8:0] and D × F[16:9] form two partial products. They are summed as PL + (PH << 9).

## Timing
- Pipeline has 3 register stages and a fixed latency of 3 cycles.
- Stage 1: register D, compute and register clamped F, register valid.
- Stage 2: register both partial products and valid.
- Stage 3: sum, shift, and register Prod and out_valid.
- Throughput: one result per cycle; back-to-back in_valid is supported.
- No backpressure input.
- out_valid equals in_valid delayed by exactly 3 cycles.
- Prod is updated only when its stage valid is 1; otherwise it holds the last result.
- Reset values: out_valid = 0, Prod = 0, all internal valid bits = 0.
- Data registers may also clear on reset.
- Reset mid-operation: in-flight results are discarded and no out_valid pulses occur for them.
- The first input after reset release is accepted on the cycle rst is 0.
- Inputs are ignored while rst = 1.

## Structure
- Shared package constants: FRAC_BITS = 16, ONE_Q16 = 17'd65536, D_WIDTH = 32.
- One natural sub-module: mul32x17_split, the stage-2/3 partial-product multiplier with registered outputs.
- Top level holds the clamp/factor stage, the valid pipeline and the final shift.

## Test plan
- D = 128, One_by_N = 32768, one in_valid pulse -> 3 cycles later out_valid = 1 and Prod = 64.
- D = 1000, One_by_N = 0 -> Prod = 1000. D = 0xFFFFFFFF, One_by_N = 1 -> Prod = 0xFFFEFFFF.
- D = 0xFFFFFFFF with One_by_N = 65536, then 70000 -> Prod = 0 for both.
- D = 100, One_by_N = 21845 -> Prod = 66 (floor of 4369100/65536).
- Stream 8 consecutive inputs (D = 1..8, One_by_N = 16384) -> 8 consecutive out_valid cycles, with Prod = floor(0.75 × D): 0, 1, 2, 3, 3, 4, 5, 6.
- Assert rst for 1 cycle while 2 inputs are in flight -> out_valid = 0 and Prod = 0 the cycle after reset, and no stale results emerge. Inputs after release produce correct results 3 cycles later.

Source files
------------

// File: rtl/into_one_minus_one_by_n_pkg.sv
// Shared constants and helpers for the (1 - 1/N) scaling pipeline.
// Q1.16 reciprocal handling and partial-product widths live here.
package into_one_minus_one_by_n_pkg;

    localparam int D_WIDTH   = 32;
    localparam int FRAC_BITS = 16;
    localparam int F_WIDTH   = FRAC_BITS + 1;
    localparam int F_LO_W    = 9;
    localparam int F_HI_W    = F_WIDTH - F_LO_W;
    localparam int PL_W      = D_WIDTH + F_LO_W;
    localparam int PH_W      = D_WIDTH + F_HI_W;
    localparam int P_W       = D_WIDTH + F_WIDTH;

    localparam logic [F_WIDTH-1:0] ONE_Q16 = 17'd65536;

    // Reciprocals above 1.0 would make the factor negative; pin it to zero.
    function automatic logic [F_WIDTH-1:0] clamp_factor(
        input logic [F_WIDTH-1:0] recip
    );
        if (recip > ONE_Q16) begin
            return '0;
        end
        return ONE_Q16 - recip;
    endfunction

endpackage

// File: rtl/into_one_minus_one_by_n_mul32x17_split.sv
// 32x17 unsigned multiplier split into two registered partial products.
// Low product uses factor bits [8:0], high product uses bits [16:9].
module mul32x17_split
    import into_one_minus_one_by_n_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic [D_WIDTH-1:0] d_i,
    input  logic [F_WIDTH-1:0] f_i,
    output logic [PL_W-1:0]    pl_o,
    output logic [PH_W-1:0]    ph_o
);

    logic [PL_W-1:0] pl_q, pl_d;
    logic [PH_W-1:0] ph_q, ph_d;

    always_comb begin
        pl_d = pl_q;
        ph_d = ph_q;
        if (en_i) begin
            pl_d = PL_W'(d_i) * PL_W'(f_i[F_LO_W-1:0]);
            ph_d = PH_W'(d_i) * PH_W'(f_i[F_WIDTH-1:F_LO_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pl_q <= '0;
            ph_q <= '0;
        end else begin
            pl_q <= pl_d;
            ph_q <= ph_d;
        end
    end

    assign pl_o = pl_q;
    assign ph_o = ph_q;

endmodule

// File: rtl/into_one_minus_one_by_n.sv
// Prod = floor(D * (1 - 1/N)) with a fixed 3-cycle pipeline latency.
// Stage 1 clamps the factor, stage 2 multiplies, stage 3 recombines.
module into_one_minus_one_by_n
    import into_one_minus_one_by_n_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [D_WIDTH-1:0] D,
    input  logic [F_WIDTH-1:0] One_by_N,
    output logic               out_valid,
    output logic [D_WIDTH-1:0] Prod
);

    logic [D_WIDTH-1:0] d_q, d_d;
    logic [F_WIDTH-1:0] f_q, f_d;
    logic               v1_q, v2_q, v3_q;
    logic [D_WIDTH-1:0] prod_q, prod_d;
    logic [PL_W-1:0]    pl;
    logic [PH_W-1:0]    ph;

    always_comb begin
        d_d = d_q;
        f_d = f_q;
        if (in_valid) begin
            d_d = D;
            f_d = clamp_factor(One_by_N);
        end
    end

    mul32x17_split u_mul (
        .clk  (clk),
        .rst  (rst),
        .en_i (v1_q),
        .d_i  (d_q),
        .f_i  (f_q),
        .pl_o (pl),
        .ph_o (ph)
    );

    // Product is below 2^48, so bits [47:16] carry the whole result.
    always_comb begin
        prod_d = prod_q;
        if (v2_q) begin
            prod_d = D_WIDTH'((P_W'(pl) + (P_W'(ph) << F_LO_W)) >> FRAC_BITS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q    <= '0;
            f_q    <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            prod_q <= '0;
        end else begin
            d_q    <= d_d;
            f_q    <= f_d;
            v1_q   <= in_valid;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            prod_q <= prod_d;
        end
    end

    assign out_valid = v3_q;
    assign Prod      = prod_q;

endmodule

// File: tb/tb_into_one_minus_one_by_n.sv
// Scoreboard bench for into_one_minus_one_by_n: expected results are
// queued with their due cycle and retired when out_valid appears.
module tb_into_one_minus_one_by_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] D = '0;
    logic [16:0] One_by_N = '0;
    logic        out_valid;
    logic [31:0] Prod;

    typedef struct {
        int          due;
        logic [31:0] prod;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    into_one_minus_one_by_n dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .D         (D),
        .One_by_N  (One_by_N),
        .out_valid (out_valid),
        .Prod      (Prod)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [31:0] d,
                                          input logic [16:0] r);
        longint unsigned f;
        f = (r > 17'd65536) ? 64'd0 : 64'd65536 - 64'(r);
        return 32'((64'(d) * f) >> 16);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            D = 32'd5000 + 32'(c);
            One_by_N = 17'd100;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid cyc=%0d got=%b exp=0", cyc, out_valid);
            end
            n_checks++;
            if (Prod !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_prod cyc=%0d got=%h exp=0", cyc, Prod);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] dv[6] = '{32'd128, 32'd1000, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100};
        logic [16:0] rv[6] = '{17'd32768, 17'd0, 17'd1,
                               17'd65536, 17'd70000, 17'd21845};
        logic [31:0] ev[6] = '{32'd64, 32'd1000, 32'hFFFE_FFFF,
                               32'd0, 32'd0, 32'd66};
        logic [31:0] last = '0;
        bit          have = 1'b0;
        int          k = 0;
        exp_t        e;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (out_valid) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL dir_unexpected cyc=%0d got=%h", cyc, Prod);
                    end else begin
                        e = sb.pop_front();
                        if (e.due != cyc || Prod !== e.prod) begin
                            n_fail++;
                            $display("FAIL dir_prod cyc=%0d got=%h exp=%h due=%0d",
                                     cyc, Prod, e.prod, e.due);
                        end
                    end
                    last = Prod;
                    have = 1'b1;
                end else begin
                    if (sb.size() > 0 && sb[0].due <= cyc) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL dir_missing cyc=%0d exp=%h due=%0d",
                                 cyc, sb[0].prod, sb[0].due);
                        void'(sb.pop_front());
                    end
                    if (have) begin
                        n_checks++;
                        if (Prod !== last) begin
                            n_fail++;
                            $display("FAIL dir_hold cyc=%0d got=%h exp=%h",
                                     cyc, Prod, last);
                        end
                    end
                end
            end
            if (c % 2 == 0 && k < 6) begin
                in_valid = 1'b1;
                D = dv[k];
                One_by_N = rv[k];
                sb.push_back('{cyc + 3, ev[k]});
                k++;
            end else begin
                in_valid = 1'b0;
                D = 32'hDEAD_BEEF;
                One_by_N = 17'd7;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ev[8] = '{32'd0, 32'd1, 32'd2, 32'd3,
                               32'd3, 32'd4, 32'd5, 32'd6};
        int   seen = 0;
        exp_t e;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_checks++;
                seen++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_unexpected cyc=%0d got=%h", cyc, Prod);
                end else begin
                    e = sb.pop_front();
                    if (e.due != cyc || Prod !== e.prod) begin
                        n_fail++;
                        $display("FAIL b2b_prod cyc=%0d got=%h exp=%h due=%0d",
                                 cyc, Prod, e.prod, e.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL b2b_missing cyc=%0d exp=%h due=%0d",
                         cyc, sb[0].prod, sb[0].due);
                void'(sb.pop_front());
            end
            if (c < 8) begin
                in_valid = 1'b1;
                D = 32'(c + 1);
                One_by_N = 17'd16384;
                sb.push_back('{cyc + 3, ev[c]});
            end else begin
                in_valid = 1'b0;
            end
        end
        n_checks++;
        if (seen != 8) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d exp=8", seen);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] d_new;
        logic [16:0] r_new;
        exp_t        e;
        @(negedge clk);
        in_valid = 1'b1;
        D = 32'd4000;
        One_by_N = 17'd1000;
        @(negedge clk);
        D = 32'd9000;
        One_by_N = 17'd2000;
        @(negedge clk);
        rst = 1'b1;
        D = 32'd7777;
        One_by_N = 17'd3;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_valid cyc=%0d got=%b exp=0", cyc, out_valid);
        end
        n_checks++;
        if (Prod !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_prod cyc=%0d got=%h exp=0", cyc, Prod);
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (out_valid) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL midrst_stale cyc=%0d got=%h", cyc, Prod);
                    end else begin
                        e = sb.pop_front();
                        if (e.due != cyc || Prod !== e.prod) begin
                            n_fail++;
                            $display("FAIL midrst_prod2 cyc=%0d got=%h exp=%h due=%0d",
                                     cyc, Prod, e.prod, e.due);
                        end
                    end
                end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL midrst_missing cyc=%0d exp=%h due=%0d",
                             cyc, sb[0].prod, sb[0].due);
                    void'(sb.pop_front());
                end
            end
            if (c < 3) begin
                d_new = $urandom();
                r_new = 17'($urandom_range(0, 65536));
                in_valid = 1'b1;
                D = d_new;
                One_by_N = r_new;
                sb.push_back('{cyc + 3, model(d_new, r_new)});
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain left=%0d exp=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
